sobel_window_loader: RTL and testbench

Raster-order pixel ingest and 3x4 window builder that feeds the Sobel gradient blocks. It accepts 8-bit pixels on a valid/ready stream, keeps the two previous image rows in internal line buffers, and presents a 12-byte, 3-row by 4-column window on data_buffer. Each window carries two overlapping 3x3 neighbourhoods, one at columns 0-2 and one at columns 1-3. It pulses enable_calc for one cycle whenever a new window is complete, which is the producer side of the gx/gy window calculators.

---
 rtl/sobel_window_loader.sv | 106 ++++++++++
 tb/tb_sobel_window_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_loader.sv
// rtl/sobel_window_loader.sv - raster pixel ingest, two-row line buffers and 3x4 Sobel window builder
module sobel_window_loader #(
   parameter int IMG_WIDTH  = 16,
   parameter int IMG_HEIGHT = 16
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             frame_start,
   input  logic [7:0]       pix_in,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic [11:0][7:0] data_buffer,
   output logic             enable_calc,
   output logic             frame_done
);
   localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] COL_THREE = CW'(3);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_ONE   = RW'(1);
   localparam logic [RW-1:0] ROW_TWO   = RW'(2);

   typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [7:0]    lb0 [IMG_WIDTH];
   logic [7:0]    lb1 [IMG_WIDTH];
   logic          accept, row_end, frame_end, restart, emit;

   assign pix_ready = ((state == FILL) || (state == ACTIVE)) && !frame_start;
   assign accept    = pix_valid && pix_ready;
   assign row_end   = (col == COL_LAST);
   assign frame_end = row_end && (row == ROW_LAST);
   assign restart   = frame_start && (state != DONE);
   // Odd columns only: each window holds two overlapping 3x3 neighbourhoods.
   assign emit      = accept && (row >= ROW_TWO) && (col >= COL_THREE) && col[0];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_start) state_nxt = FILL;
         FILL: begin
            if (frame_start)
               state_nxt = FILL;
            else if (accept && row_end && (row == ROW_ONE))
               state_nxt = ACTIVE;
         end
         ACTIVE: begin
            if (frame_start)
               state_nxt = FILL;
            else if (accept && frame_end)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         enable_calc <= 1'b0;
         frame_done  <= 1'b0;
         data_buffer <= '0;
         for (int i = 0; i < IMG_WIDTH; i++) begin
            lb0[i] <= '0;
            lb1[i] <= '0;
         end
      end else begin
         state       <= state_nxt;
         enable_calc <= emit;
         frame_done  <= accept && frame_end && (state == ACTIVE);

         if (restart) begin
            col <= '0;
            row <= '0;
         end else if (accept) begin
            if (row_end) begin
               col <= '0;
               row <= frame_end ? '0 : row + ROW_ONE;
            end else begin
               col <= col + CW'(1);
            end
         end

         // Line buffers and window are left alone on abort; the next frame overwrites them.
         if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_in;
            for (int r = 0; r < 3; r++) begin
               data_buffer[r*4 + 0] <= data_buffer[r*4 + 1];
               data_buffer[r*4 + 1] <= data_buffer[r*4 + 2];
               data_buffer[r*4 + 2] <= data_buffer[r*4 + 3];
            end
            data_buffer[3]  <= lb1[col];
            data_buffer[7]  <= lb0[col];
            data_buffer[11] <= pix_in;
         end
      end
   end
endmodule

// File: tb/tb_sobel_window_loader.sv
// tb/tb_sobel_window_loader.sv - self-checking bench for sobel_window_loader
module tb_sobel_window_loader;
   localparam int W = 16;
   localparam int H = 16;

   logic             clk = 1'b0;
   logic             n_rst;
   logic             frame_start, pix_valid, pix_ready, enable_calc, frame_done;
   logic [7:0]       pix_in;
   logic [11:0][7:0] data_buffer;

   logic             s_fs, s_valid, s_ready, s_en, s_fd;
   logic [7:0]       s_pix;
   logic [11:0][7:0] s_db;

   always #5 clk = ~clk;

   sobel_window_loader #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .n_rst(n_rst), .frame_start(frame_start), .pix_in(pix_in),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .data_buffer(data_buffer),
      .enable_calc(enable_calc), .frame_done(frame_done));

   sobel_window_loader #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) dut_s (
      .clk(clk), .n_rst(n_rst), .frame_start(s_fs), .pix_in(s_pix),
      .pix_valid(s_valid), .pix_ready(s_ready), .data_buffer(s_db),
      .enable_calc(s_en), .frame_done(s_fd));

   int          n_checks = 0;
   int          n_err    = 0;
   bit          in_frame = 0;
   bit          done_phase = 0;
   int          pos = 0;
   int          en_cnt = 0;
   int          fd_cnt = 0;
   logic [7:0]  img [H][W];

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check pix_ready, predict from image geometry, check outputs.
   task automatic cyc(input logic fs, input logic v, input logic [7:0] p);
      bit          acc, exp_rdy, exp_en, exp_fd, done_next;
      int          r, c;
      logic [95:0] exp_win;
      frame_start = fs; pix_valid = v; pix_in = p;
      #1;
      exp_rdy = in_frame && !fs;
      chk("pix_ready", 96'(pix_ready), 96'(exp_rdy));
      acc = exp_rdy && v;
      exp_en = 0; exp_fd = 0; done_next = 0; exp_win = '0;
      if (fs && !done_phase) begin
         in_frame = 1;
         pos = 0;
      end
      if (acc) begin
         r = pos / W;
         c = pos % W;
         img[r][c] = p;
         if (r >= 2 && c >= 3 && (c % 2) == 1) begin
            exp_en = 1;
            for (int rr = 0; rr < 3; rr++)
               for (int cc = 0; cc < 4; cc++)
                  exp_win[(rr*4 + cc)*8 +: 8] = img[r-2+rr][c-3+cc];
         end
         if (pos == W*H - 1) begin
            exp_fd = 1;
            in_frame = 0;
            done_next = 1;
         end else begin
            pos++;
         end
      end
      @(posedge clk);
      #1;
      done_phase = done_next;
      en_cnt += int'(enable_calc);
      fd_cnt += int'(frame_done);
      chk("enable_calc", 96'(enable_calc), 96'(exp_en));
      chk("frame_done", 96'(frame_done), 96'(exp_fd));
      if (exp_en) chk("window", data_buffer, exp_win);
   endtask

   // mode 0: ramp full rate, 1: ramp with valid every other cycle, 2: random data and gaps
   task automatic stream(input int mode, input int first, input int npix);
      logic [7:0] val;
      for (int k = first; k < first + npix; k++) begin
         val = (mode == 2) ? 8'($urandom_range(0, 255)) : 8'(k);
         cyc(1'b0, 1'b1, val);
         if (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0))
            cyc(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      end
   endtask

   task automatic full_frame(input int mode);
      en_cnt = 0; fd_cnt = 0;
      cyc(1'b1, 1'b0, 8'h00);
      stream(mode, 0, W*H);
      chk("frame_en_count", 96'(en_cnt), 96'(98));
      chk("frame_fd_count", 96'(fd_cnt), 96'(1));
      cyc(1'b1, 1'b1, 8'h55);
      cyc(1'b0, 1'b1, 8'h66);
   endtask

   initial begin
      logic [95:0] small_win;
      n_rst = 1'b0; frame_start = 0; pix_valid = 0; pix_in = 0;
      s_fs = 0; s_valid = 0; s_pix = 0;
      #12;
      chk("reset_db", data_buffer, 96'h0);
      chk("reset_en", 96'(enable_calc), 96'h0);
      chk("reset_fd", 96'(frame_done), 96'h0);
      chk("reset_rdy", 96'(pix_ready), 96'h0);
      n_rst = 1'b1;
      cyc(1'b0, 1'b1, 8'h11);
      cyc(1'b0, 1'b1, 8'h22);

      full_frame(0);
      full_frame(1);
      full_frame(2);

      // Abort after 40 pixels, then a fresh frame.
      cyc(1'b1, 1'b0, 8'h00);
      stream(2, 0, 40);
      en_cnt = 0; fd_cnt = 0;
      cyc(1'b1, 1'b1, 8'hAA);
      stream(2, 0, W*H);
      chk("abort_en_count", 96'(en_cnt), 96'(98));
      chk("abort_fd_count", 96'(fd_cnt), 96'(1));
      cyc(1'b0, 1'b0, 8'h00);

      // Asynchronous reset mid row 5, just after a window was emitted.
      cyc(1'b1, 1'b0, 8'h00);
      stream(0, 0, 5*W + 8);
      #2;
      n_rst = 1'b0;
      #1;
      chk("areset_db", data_buffer, 96'h0);
      chk("areset_en", 96'(enable_calc), 96'h0);
      chk("areset_fd", 96'(frame_done), 96'h0);
      chk("areset_rdy", 96'(pix_ready), 96'h0);
      in_frame = 0; done_phase = 0;
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(i));
      full_frame(2);

      // 4x3 image: a single window 1..12.
      for (int k = 0; k < 12; k++) small_win[k*8 +: 8] = 8'(k + 1);
      s_fs = 1;
      @(posedge clk);
      #1;
      s_fs = 0;
      for (int i = 1; i <= 12; i++) begin
         s_valid = 1; s_pix = 8'(i);
         #1;
         chk("small_ready", 96'(s_ready), 96'h1);
         @(posedge clk);
         #1;
         chk("small_en", 96'(s_en), 96'(i == 12));
         chk("small_fd", 96'(s_fd), 96'(i == 12));
         if (i == 12) chk("small_window", s_db, small_win);
      end
      s_valid = 0;
      #1;
      chk("small_ready_done", 96'(s_ready), 96'h0);
      @(posedge clk);
      #1;
      chk("small_en_after", 96'(s_en), 96'h0);
      chk("small_fd_after", 96'(s_fd), 96'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
